z80_sram_ctrl: RTL and testbench
================================

Z80_SRAM_CTRL -- requirements
Module: z80_sram_ctrl

Interface
REQ-001 Parameter PA, default 12: physical page-number width; the physical address is PA+8 bits.
REQ-002 Parameter WAIT_CYCLES, default 2: clk cycles the SRAM strobe is held active, range 1..15.
REQ-003 Parameter SYNC_STAGES, default 2: flops per Z80 strobe synchronizer, range 2..3.
REQ-004 Port clk, input, 1: single system clock; every flop is on its rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Ports nMREQ, nRD, nWR, nRFSH, input, 1 each: asynchronous Z80 bus strobes, active low.
REQ-007 Port ram_addr, input, PA+8: physical address from Z80_MMU; may be 'z' while nMREQ is high.
REQ-008 Port cpu_wdata, input, 8: CPU write data.
REQ-009 Port cpu_rdata, output, 8: latched SRAM read data, returned to the CPU.
REQ-010 Port sram_addr, output, PA+8: SRAM address.
REQ-011 Port sram_dq_in, input, 8: SRAM data in.
REQ-012 Port sram_dq_out, output, 8: SRAM data out.
REQ-013 Port sram_dq_oe, output, 1: high drives sram_dq_out onto the SRAM bus.
REQ-014 Ports sram_nCE, sram_nOE, sram_nWE, output, 1 each: SRAM strobes, active low.
REQ-015 Port nWAIT, output, 1: Z80 wait request, active low.
REQ-016 Port busy, output, 1: high whenever the FSM is not in IDLE.

Function
REQ-017 nMREQ, nRD, nWR and nRFSH shall each pass through a SYNC_STAGES-flop synchronizer (reset value 1) before use.
REQ-018 FSM states: IDLE, SETUP, RD_ACC, WR_ACC, DONE.
REQ-019 IDLE->SETUP when the synchronized nMREQ is 0 and nRFSH is 1; ram_addr is latched into sram_addr on that edge.
REQ-020 When nMREQ is low and nRFSH is low (refresh cycle), the FSM shall stay in IDLE and no SRAM strobe shall assert.
REQ-021 SETUP->RD_ACC when nRD is 0, or SETUP->WR_ACC when nWR is 0; SETUP->IDLE if nMREQ returns high first (aborted cycle).
REQ-022 If nRD and nWR are both 0 in SETUP, RD_ACC shall win.
REQ-023 RD_ACC: sram_nCE=0 and sram_nOE=0 for exactly WAIT_CYCLES cycles; sram_dq_in is latched into cpu_rdata on the last cycle; then ->DONE.
REQ-024 WR_ACC: cpu_wdata is latched into sram_dq_out on entry; sram_dq_oe=1 for the whole state; sram_nWE=0 for WAIT_CYCLES cycles, framed by one cycle of oe-only setup and one of oe-only hold (WAIT_CYCLES+2 cycles total); then ->DONE.
REQ-025 DONE->IDLE once the synchronized nMREQ is 1; no new access starts until then.
REQ-026 The wait counter shall be 4 bits, loaded on state entry and decremented to 0; no wrap-around.
REQ-027 sram_nOE and sram_nWE shall never be 0 together, and sram_dq_oe shall never be 1 while sram_nOE is 0.
REQ-028 cpu_rdata shall hold its value until the next read completes.

Reset
REQ-029 rst=1 on a clk edge shall force: state IDLE; sram_nCE, sram_nOE, sram_nWE, nWAIT and the synchronizer flops to 1; sram_dq_oe and busy to 0; sram_addr, sram_dq_out and cpu_rdata to 0.
REQ-030 Reset asserted mid-access shall abort the access in the same edge, with no further strobe activity.

Configuration
REQ-031 Macro Z80_SRAM_NWAIT_EN, when defined, shall drive nWAIT=0 from SETUP exit until the cycle before DONE.
REQ-032 Without Z80_SRAM_NWAIT_EN, nWAIT shall be constant 1 and the CPU clock shall be slow enough to cover the access.

Structure
REQ-033 Package z80_pkg shall hold the FSM state encoding and the default values of PA and WAIT_CYCLES; Z80_MMU shall use the same PA.
REQ-034 A sub-module z80_sync (parameterised by SYNC_STAGES, with reset value 1) shall implement the strobe synchronizer.

Verification
REQ-035 Read: ram_addr=20'h8E0FF, sram_dq_in=8'h7F, nMREQ/nRD low -> sram_addr=20'h8E0FF, sram_nOE low for 2 cycles, cpu_rdata=8'h7F.
REQ-036 Write: ram_addr=20'h000AC, cpu_wdata=8'hFF, nWR low -> sram_nWE low for 2 cycles with sram_dq_oe high for 4 cycles, sram_dq_out=8'hFF.
REQ-037 Refresh: nMREQ=0 with nRFSH=0 for 10 cycles -> busy=0 and all SRAM strobes stay high.
REQ-038 Abort: nMREQ low for 3 cycles with nRD and nWR high -> return to IDLE with no strobes.
REQ-039 Reset mid-read: rst=1 in the second RD_ACC cycle -> next cycle all strobes are 1, busy=0, and cpu_rdata=0.
REQ-040 NWAIT: with Z80_SRAM_NWAIT_EN defined, the read of REQ-035 -> nWAIT low for exactly the RD_ACC cycles; without the macro, nWAIT stays 1 throughout.

Source files
------------

// File: rtl/z80_pkg.sv
// Shared definitions for the Z80 SRAM controller: FSM state encoding,
// default physical-page width and SRAM access length, shared with Z80_MMU.
package z80_pkg;

  localparam int PA_DEF          = 12;
  localparam int WAIT_CYCLES_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_RD_ACC = 3'd2,
    ST_WR_ACC = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Clamp a cycle count into the 4-bit wait counter range without wrapping.
  function automatic logic [3:0] wait_load(input int cycles);
    if (cycles < 0)
      wait_load = 4'd0;
    else if (cycles > 15)
      wait_load = 4'd15;
    else
      wait_load = 4'(cycles);
  endfunction

endpackage

// File: rtl/z80_sync.sv
// Multi-flop synchronizer for one asynchronous, active-low Z80 strobe.
// Resets to 1 so a strobe reads as inactive while the chain refills.
module z80_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] ff_q;

  always_ff @(posedge clk) begin
    if (rst)
      ff_q <= '1;
    else
      ff_q <= {ff_q[SYNC_STAGES-2:0], d_i};
  end

  assign q_o = ff_q[SYNC_STAGES-1];

endmodule

// File: rtl/z80_sram_ctrl.sv
// Z80 bus to asynchronous SRAM controller with synchronized CPU strobes.
// Optional macro Z80_SRAM_NWAIT_EN drives nWAIT low during SRAM accesses.
module z80_sram_ctrl
  import z80_pkg::*;
#(
  parameter int PA          = PA_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          nMREQ,
  input  logic          nRD,
  input  logic          nWR,
  input  logic          nRFSH,
  input  logic [PA+7:0] ram_addr,
  input  logic [7:0]    cpu_wdata,
  output logic [7:0]    cpu_rdata,
  output logic [PA+7:0] sram_addr,
  input  logic [7:0]    sram_dq_in,
  output logic [7:0]    sram_dq_out,
  output logic          sram_dq_oe,
  output logic          sram_nCE,
  output logic          sram_nOE,
  output logic          sram_nWE,
  output logic          nWAIT,
  output logic          busy
);

  localparam logic [3:0] RD_LOAD = wait_load(WAIT_CYCLES - 1);
  localparam logic [3:0] WR_LOAD = wait_load(WAIT_CYCLES);

  logic s_mreq_n, s_rd_n, s_wr_n, s_rfsh_n;

  z80_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mreq (
    .clk(clk), .rst(rst), .d_i(nMREQ), .q_o(s_mreq_n)
  );
  z80_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rd (
    .clk(clk), .rst(rst), .d_i(nRD), .q_o(s_rd_n)
  );
  z80_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_wr (
    .clk(clk), .rst(rst), .d_i(nWR), .q_o(s_wr_n)
  );
  z80_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rfsh (
    .clk(clk), .rst(rst), .d_i(nRFSH), .q_o(s_rfsh_n)
  );

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic [PA+7:0] addr_q;
  logic [7:0]    rdata_q;
  logic [7:0]    wdata_q;
  logic          dq_oe_q;
  logic          nce_q;
  logic          noe_q;
  logic          nwe_q;
`ifdef Z80_SRAM_NWAIT_EN
  logic          nwait_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      rdata_q <= 8'h00;
      wdata_q <= 8'h00;
      dq_oe_q <= 1'b0;
      nce_q   <= 1'b1;
      noe_q   <= 1'b1;
      nwe_q   <= 1'b1;
`ifdef Z80_SRAM_NWAIT_EN
      nwait_q <= 1'b1;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // Refresh cycles (nRFSH low) never touch the SRAM.
          if (!s_mreq_n && s_rfsh_n) begin
            addr_q  <= ram_addr;
            state_q <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (s_mreq_n) begin
            state_q <= ST_IDLE;
          end else if (!s_rd_n) begin
            cnt_q   <= RD_LOAD;
            nce_q   <= 1'b0;
            noe_q   <= 1'b0;
            state_q <= ST_RD_ACC;
`ifdef Z80_SRAM_NWAIT_EN
            nwait_q <= 1'b0;
`endif
          end else if (!s_wr_n) begin
            cnt_q   <= WR_LOAD;
            wdata_q <= cpu_wdata;
            dq_oe_q <= 1'b1;
            nce_q   <= 1'b0;
            state_q <= ST_WR_ACC;
`ifdef Z80_SRAM_NWAIT_EN
            nwait_q <= 1'b0;
`endif
          end
        end

        ST_RD_ACC: begin
          if (cnt_q == 4'd0) begin
            rdata_q <= sram_dq_in;
            nce_q   <= 1'b1;
            noe_q   <= 1'b1;
            state_q <= ST_DONE;
`ifdef Z80_SRAM_NWAIT_EN
            nwait_q <= 1'b1;
`endif
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end

        ST_WR_ACC: begin
          // nWE high with a nonzero count is the setup cycle; at zero it is the hold cycle.
          if (nwe_q) begin
            if (cnt_q == 4'd0) begin
              dq_oe_q <= 1'b0;
              nce_q   <= 1'b1;
              state_q <= ST_DONE;
`ifdef Z80_SRAM_NWAIT_EN
              nwait_q <= 1'b1;
`endif
            end else begin
              nwe_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1)
              nwe_q <= 1'b1;
          end
        end

        ST_DONE: begin
          if (s_mreq_n)
            state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cpu_rdata   = rdata_q;
  assign sram_addr   = addr_q;
  assign sram_dq_out = wdata_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_nCE    = nce_q;
  assign sram_nOE    = noe_q;
  assign sram_nWE    = nwe_q;
  assign busy        = (state_q != ST_IDLE);

`ifdef Z80_SRAM_NWAIT_EN
  assign nWAIT = nwait_q;
`else
  assign nWAIT = 1'b1;
`endif

endmodule

// File: tb/tb_z80_sram_ctrl.sv
// Randomized bench for z80_sram_ctrl against a transaction-level model.
// Honours Z80_SRAM_NWAIT_EN for the nWAIT expectations.
module tb_z80_sram_ctrl;

  localparam int PA = 12;
  localparam int W  = 2;
  localparam int AW = PA + 8;

  localparam int K_READ = 0, K_WRITE = 1, K_BOTH = 2, K_RFSH = 3, K_ABORT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          nMREQ, nRD, nWR, nRFSH;
  logic [AW-1:0] ram_addr;
  logic [7:0]    cpu_wdata;
  logic [7:0]    cpu_rdata;
  logic [AW-1:0] sram_addr;
  logic [7:0]    sram_dq_in;
  logic [7:0]    sram_dq_out;
  logic          sram_dq_oe, sram_nCE, sram_nOE, sram_nWE, nWAIT, busy;

  z80_sram_ctrl #(.PA(PA), .WAIT_CYCLES(W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst),
    .nMREQ(nMREQ), .nRD(nRD), .nWR(nWR), .nRFSH(nRFSH),
    .ram_addr(ram_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .sram_addr(sram_addr), .sram_dq_in(sram_dq_in), .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe), .sram_nCE(sram_nCE), .sram_nOE(sram_nOE),
    .sram_nWE(sram_nWE), .nWAIT(nWAIT), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Per-transaction observations
  int            oe_n, we_n, dqoe_n, ce_n, wait_n, busy_n;
  logic [AW-1:0] seen_addr;
  logic [7:0]    seen_dq;
  logic [7:0]    model_rd;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_obs();
    oe_n = 0; we_n = 0; dqoe_n = 0; ce_n = 0; wait_n = 0; busy_n = 0;
    seen_addr = '0;
    seen_dq   = 8'h00;
  endtask

  // Advance one clock, sample just after the edge, check bus-safety rules.
  task automatic tick();
    @(posedge clk);
    #1;
    chk_eq("oe_we_overlap", {31'b0, (!sram_nOE && !sram_nWE)}, 32'd0);
    chk_eq("dqoe_while_oe", {31'b0, (sram_dq_oe && !sram_nOE)}, 32'd0);
    chk_eq("strobe_wo_ce", {31'b0, ((!sram_nOE || !sram_nWE) && sram_nCE)}, 32'd0);
    if (!sram_nOE)  oe_n++;
    if (!sram_nWE)  begin we_n++; seen_dq = sram_dq_out; end
    if (sram_dq_oe) dqoe_n++;
    if (!sram_nCE)  begin ce_n++; seen_addr = sram_addr; end
    if (!nWAIT)     wait_n++;
    if (busy)       busy_n++;
  endtask

  task automatic release_bus();
    nMREQ = 1'b1; nRD = 1'b1; nWR = 1'b1; nRFSH = 1'b1;
    ram_addr = 'z;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy; i++) tick();
    chk_eq("idle_timeout", {31'b0, busy}, 32'd0);
    repeat (3) tick();
  endtask

  task automatic run_txn(input int kind, input logic [AW-1:0] addr,
                         input logic [7:0] wd, input logic [7:0] rd, input int dly);
    clr_obs();
    ram_addr   = addr;
    cpu_wdata  = wd;
    sram_dq_in = rd;
    nMREQ      = 1'b0;
    case (kind)
      K_READ:  nRD = 1'b0;
      K_BOTH:  begin nRD = 1'b0; nWR = 1'b0; end
      K_RFSH:  nRFSH = 1'b0;
      default: ;
    endcase
    if (kind == K_WRITE) begin
      repeat (dly) tick();
      nWR = 1'b0;
    end
    if (kind == K_RFSH)
      repeat (10) tick();
    else if (kind == K_ABORT)
      repeat (3) tick();
    else
      repeat (W + 8 + $urandom_range(0, 3)) tick();
    release_bus();
    wait_idle();

    case (kind)
      K_READ, K_BOTH: begin
        model_rd = rd;
        chk_eq("rd_oe_cycles", oe_n, W);
        chk_eq("rd_ce_cycles", ce_n, W);
        chk_eq("rd_we_cycles", we_n, 0);
        chk_eq("rd_dqoe_cycles", dqoe_n, 0);
        chk_eq("rd_addr", 32'(seen_addr), 32'(addr));
`ifdef Z80_SRAM_NWAIT_EN
        chk_eq("rd_nwait_cycles", wait_n, W);
`else
        chk_eq("rd_nwait_cycles", wait_n, 0);
`endif
      end
      K_WRITE: begin
        chk_eq("wr_we_cycles", we_n, W);
        chk_eq("wr_dqoe_cycles", dqoe_n, W + 2);
        chk_eq("wr_oe_cycles", oe_n, 0);
        chk_eq("wr_dq", 32'(seen_dq), 32'(wd));
        chk_eq("wr_addr", 32'(seen_addr), 32'(addr));
`ifdef Z80_SRAM_NWAIT_EN
        chk_eq("wr_nwait_cycles", wait_n, W + 2);
`else
        chk_eq("wr_nwait_cycles", wait_n, 0);
`endif
      end
      default: begin
        chk_eq("nop_ce_cycles", ce_n, 0);
        chk_eq("nop_oe_cycles", oe_n, 0);
        chk_eq("nop_we_cycles", we_n, 0);
        chk_eq("nop_dqoe_cycles", dqoe_n, 0);
        chk_eq("nop_nwait_cycles", wait_n, 0);
        if (kind == K_RFSH)
          chk_eq("rfsh_busy_cycles", busy_n, 0);
      end
    endcase
    chk_eq("rdata_hold", 32'(cpu_rdata), 32'(model_rd));
  endtask

  initial begin
    rst = 1'b1;
    release_bus();
    cpu_wdata  = 8'h00;
    sram_dq_in = 8'h00;
    model_rd   = 8'h00;
    clr_obs();
    repeat (3) tick();
    chk_eq("rst_nce", {31'b0, sram_nCE}, 32'd1);
    chk_eq("rst_noe", {31'b0, sram_nOE}, 32'd1);
    chk_eq("rst_nwe", {31'b0, sram_nWE}, 32'd1);
    chk_eq("rst_nwait", {31'b0, nWAIT}, 32'd1);
    chk_eq("rst_dqoe", {31'b0, sram_dq_oe}, 32'd0);
    chk_eq("rst_busy", {31'b0, busy}, 32'd0);
    chk_eq("rst_addr", 32'(sram_addr), 32'd0);
    chk_eq("rst_dqout", 32'(sram_dq_out), 32'd0);
    chk_eq("rst_rdata", 32'(cpu_rdata), 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    run_txn(K_READ,  20'h8E0FF, 8'h00, 8'h7F, 0);
    run_txn(K_WRITE, 20'h000AC, 8'hFF, 8'h11, 0);
    run_txn(K_RFSH,  20'h12345, 8'h5A, 8'hA5, 0);
    run_txn(K_ABORT, 20'h54321, 8'h33, 8'hCC, 0);
    run_txn(K_BOTH,  20'hFFFFF, 8'h01, 8'h80, 0);
    run_txn(K_WRITE, 20'h00000, 8'h00, 8'hEE, 2);

    for (int t = 0; t < 40; t++)
      run_txn($urandom_range(0, 4), AW'($urandom), 8'($urandom),
              8'($urandom), $urandom_range(0, 2));

    // Reset during the second read-strobe cycle
    clr_obs();
    ram_addr   = 20'h0BEEF;
    sram_dq_in = 8'h42;
    nMREQ      = 1'b0;
    nRD        = 1'b0;
    for (int i = 0; i < 20 && oe_n == 0; i++) tick();
    chk_eq("rr_oe_seen", oe_n, 1);
    tick();
    rst = 1'b1;
    release_bus();
    tick();
    chk_eq("rr_nce", {31'b0, sram_nCE}, 32'd1);
    chk_eq("rr_noe", {31'b0, sram_nOE}, 32'd1);
    chk_eq("rr_nwe", {31'b0, sram_nWE}, 32'd1);
    chk_eq("rr_busy", {31'b0, busy}, 32'd0);
    chk_eq("rr_rdata", 32'(cpu_rdata), 32'd0);
    model_rd = 8'h00;
    rst = 1'b0;
    clr_obs();
    repeat (6) tick();
    chk_eq("rr_no_restart", ce_n, 0);

    run_txn(K_READ, 20'h13579, 8'h00, 8'h3C, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
